mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// - Responder side of the CPU memory request interface: accepts imemREN / dmemREN / dmemWEN from the
//   datapath request logic and returns ihit / dhit with load data.
// - Arbitrates both ports onto one single-ported RAM; data port has priority over instruction port.
// - Sits between the datapath and the RAM model; the only block that drives ram* signals.
// PARAMETERS
// - TIMEOUT   64   max cycles a granted access may wait for ACCESS before memerr sets (>=2)
// - CNT_W     16   width of the optional statistics counters
// PORTS
// - CLK        in   1    clock, all state updates on rising edge
// - RST        in   1    synchronous reset, active-high
// - imemREN    in   1    instruction read request, held until ihit
// - imemaddr   in   32   instruction address (word_t)
// - ihit       out  1    one-cycle pulse: iload valid
// - iload      out  32   instruction read data, held until next ihit
// - dmemREN    in   1    data read request, held until dhit
// - dmemWEN    in   1    data write request, held until dhit
// - dmemaddr   in   32   data address
// - dmemstore  in   32   data write value
// - dhit       out  1    one-cycle pulse: data access complete, dmemload valid on reads
// - dmemload   out  32   data read data, held until next read dhit
// - ramREN     out  1    RAM read strobe
// - ramWEN     out  1    RAM write strobe
// - ramaddr    out  32   RAM address
// - ramstore   out  32   RAM write data
// - ramload    in   32   RAM read data, valid when ramstate==ACCESS
// - ramstate   in   2    ramstate_t: FREE, BUSY, ACCESS, ERROR
// - memerr     out  1    sticky error flag: RAM ERROR or timeout, cleared only by RST
// BEHAVIOUR
// - Reset: state IDLE; ihit, dhit, ramREN, ramWEN, memerr = 0; iload, dmemload, ramaddr, ramstore = 0.
//   RST mid-access abandons it: no hit is issued and strobes drop on the next edge.
// - FSM states: IDLE, DGRANT, IGRANT, DONE.
// - IDLE: if dmemWEN|dmemREN -> DGRANT, else if imemREN -> IGRANT. Address/store/op are latched at this edge.
//   dmemWEN and dmemREN both high -> handled as a write.
// - DGRANT/IGRANT: ramREN/ramWEN/ramaddr/ramstore driven from the latched request (registered, stable).
//   Requester inputs are ignored while granted.
// - ramstate==ACCESS -> latch ramload into dmemload/iload (reads only), pulse dhit/ihit the next cycle, -> DONE.
// - ramstate==ERROR -> set memerr, -> IDLE with no hit (the requester retries because its request is still held).
// - Wait counter clears on grant and counts FREE/BUSY cycles; at count==TIMEOUT-1 set memerr and -> IDLE, no hit.
// - DONE: hit pulse cycle; strobes low; no new request is sampled; -> IDLE. This absorbs the requester's
//   one-cycle request drop latency and prevents a duplicate access.
// - Latency: request seen in IDLE -> strobes next cycle -> hit 1 cycle after the first ACCESS.
//   Minimum is 3 cycles from request to hit.
// - ihit and dhit are never high in the same cycle. Exactly one hit is issued per completed access.
// - Starvation: after DONE from a data access, IDLE re-arbitrates with data priority again (no fairness
//   is required; the datapath holds fetch while stalled on data).
// CONFIGURATION
// - MEM_RESP_STATS_EN defined: adds outputs icount, dcount, waitcount (CNT_W each). These count ihits,
//   dhits, and granted non-ACCESS cycles. They saturate at all-ones and clear on RST.
// - Not defined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
// - cpu_types_pkg: word_t, ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3), new enum mresp_state_t.
// - Single module; no sub-module (the wait counter and stats counters are inline).
// TESTING
// - Read: imemREN=1, imemaddr=0x40, ramload=0x8C220004, ACCESS on 2nd granted cycle
//   -> ramaddr=0x40, ramREN=1, ihit one pulse, iload=0x8C220004.
// - Contention: imemREN and dmemREN asserted the same cycle
//   -> DGRANT first, dhit, DONE, then IGRANT, ihit; never simultaneous hits.
// - Write: dmemWEN=1, dmemaddr=0x100, dmemstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, dhit, dmemload unchanged.
// - Error/timeout: ramstate stays BUSY 64 cycles -> memerr=1 on cycle 64, no hit, FSM back in IDLE.
//   ramstate=ERROR -> memerr=1 next cycle.
// - Reset: RST asserted mid-DGRANT -> next cycle ramREN=ramWEN=dhit=0, state IDLE, memerr=0, no late dhit after RST drops.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory types: word, RAM handshake state and responder FSM state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2,
      DONE   = 2'd3
   } mresp_state_t;

endpackage

// File: rtl/mem_responder.sv
// Arbitrates instruction and data requests onto one single-ported RAM, data first.
// Define MEM_RESP_STATS_EN to add saturating icount/dcount/waitcount outputs.
module mem_responder
   import cpu_types_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      imemREN,
   input  word_t     imemaddr,
   output logic      ihit,
   output word_t     iload,
   input  logic      dmemREN,
   input  logic      dmemWEN,
   input  word_t     dmemaddr,
   input  word_t     dmemstore,
   output logic      dhit,
   output word_t     dmemload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      memerr
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [CNT_W-1:0] icount,
   output logic [CNT_W-1:0] dcount,
   output logic [CNT_W-1:0] waitcount
`endif
);

   localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("mem_responder: TIMEOUT must be at least 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("mem_responder: CNT_W must be at least 1");
   end

   mresp_state_t      state_q, state_d;
   logic              is_data_q, is_data_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              ram_ren_q, ram_ren_d;
   logic              ram_wen_q, ram_wen_d;
   word_t             ram_addr_q, ram_addr_d;
   word_t             ram_store_q, ram_store_d;
   logic              ihit_q, ihit_d;
   logic              dhit_q, dhit_d;
   word_t             iload_q, iload_d;
   word_t             dmemload_q, dmemload_d;
   logic              memerr_q, memerr_d;
   logic              granted;

   assign granted = (state_q == DGRANT) || (state_q == IGRANT);

   always_comb begin
      state_d     = state_q;
      is_data_d   = is_data_q;
      wait_d      = wait_q;
      ram_ren_d   = ram_ren_q;
      ram_wen_d   = ram_wen_q;
      ram_addr_d  = ram_addr_q;
      ram_store_d = ram_store_q;
      ihit_d      = 1'b0;
      dhit_d      = 1'b0;
      iload_d     = iload_q;
      dmemload_d  = dmemload_q;
      memerr_d    = memerr_q;

      unique case (state_q)
         IDLE: begin
            wait_d = '0;
            // A simultaneous read and write on the data port is treated as a write.
            if (dmemWEN || dmemREN) begin
               state_d     = DGRANT;
               is_data_d   = 1'b1;
               ram_wen_d   = dmemWEN;
               ram_ren_d   = ~dmemWEN;
               ram_addr_d  = dmemaddr;
               ram_store_d = dmemstore;
            end else if (imemREN) begin
               state_d    = IGRANT;
               is_data_d  = 1'b0;
               ram_wen_d  = 1'b0;
               ram_ren_d  = 1'b1;
               ram_addr_d = imemaddr;
            end
         end
         DGRANT, IGRANT: begin
            if (ramstate == ACCESS) begin
               state_d   = DONE;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               if (is_data_q) begin
                  dhit_d = 1'b1;
                  if (ram_ren_q) dmemload_d = ramload;
               end else begin
                  ihit_d  = 1'b1;
                  iload_d = ramload;
               end
            end else if (ramstate == ERROR || wait_q == WAIT_W'(TIMEOUT - 1)) begin
               state_d   = IDLE;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               memerr_d  = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         is_data_q   <= 1'b0;
         wait_q      <= '0;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
         ihit_q      <= 1'b0;
         dhit_q      <= 1'b0;
         iload_q     <= '0;
         dmemload_q  <= '0;
         memerr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_data_q   <= is_data_d;
         wait_q      <= wait_d;
         ram_ren_q   <= ram_ren_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_store_q <= ram_store_d;
         ihit_q      <= ihit_d;
         dhit_q      <= dhit_d;
         iload_q     <= iload_d;
         dmemload_q  <= dmemload_d;
         memerr_q    <= memerr_d;
      end
   end

   assign ihit     = ihit_q;
   assign dhit     = dhit_q;
   assign iload    = iload_q;
   assign dmemload = dmemload_q;
   assign ramREN   = ram_ren_q;
   assign ramWEN   = ram_wen_q;
   assign ramaddr  = ram_addr_q;
   assign ramstore = ram_store_q;
   assign memerr   = memerr_q;

`ifdef MEM_RESP_STATS_EN
   logic [CNT_W-1:0] icount_q, icount_d;
   logic [CNT_W-1:0] dcount_q, dcount_d;
   logic [CNT_W-1:0] waitcount_q, waitcount_d;

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      icount_d    = icount_q;
      dcount_d    = dcount_q;
      waitcount_d = waitcount_q;
      if (ihit_q && icount_q != '1) icount_d = icount_q + CNT_W'(1);
      if (dhit_q && dcount_q != '1) dcount_d = dcount_q + CNT_W'(1);
      if (granted && ramstate != ACCESS && waitcount_q != '1)
         waitcount_d = waitcount_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         icount_q    <= '0;
         dcount_q    <= '0;
         waitcount_q <= '0;
      end else begin
         icount_q    <= icount_d;
         dcount_q    <= dcount_d;
         waitcount_q <= waitcount_d;
      end
   end

   assign icount    = icount_q;
   assign dcount    = dcount_q;
   assign waitcount = waitcount_q;
`else
   logic unused_granted;
   assign unused_granted = granted;
`endif

endmodule
